// File: rtl/riscv_ctrl_pipe.sv
// riscv_ctrl_pipe
// Control-path register chain between the decode-stage controller and the
// E/M/W stages. Captures the D-stage control bundle plus destination register,
// carries it through E, M and W, resolves branches/jumps in E into pcSrcE,
// and exposes per-stage rd/regWrite/load indications for hazard detection.
//
// Optional feature macro: CTRL_PIPE_PERF_EN
//   When defined, adds retiredCnt/flushCnt performance counters (CNT_W wide).
//   When undefined, neither the ports, the CNT_W parameter nor the counters exist.

module riscv_ctrl_pipe #(
  parameter int RD_W  = 5
`ifdef CTRL_PIPE_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validD,
  input  logic            flushE,
  input  logic            regWriteD,
  input  logic [1:0]      resultSrcD,
  input  logic            memWriteD,
  input  logic [1:0]      jumpD,
  input  logic [2:0]      branchD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [RD_W-1:0] rdD,
  input  logic            zeroE,
  input  logic            ltE,
  input  logic            ltuE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [1:0]      pcSrcE,
  output logic            loadE,
  output logic [RD_W-1:0] rdE,
  output logic            regWriteM,
  output logic            memWriteM,
  output logic [1:0]      resultSrcM,
  output logic [RD_W-1:0] rdM,
  output logic            regWriteW,
  output logic [1:0]      resultSrcW,
`ifdef CTRL_PIPE_PERF_EN
  output logic [CNT_W-1:0] retiredCnt,
  output logic [CNT_W-1:0] flushCnt,
`endif
  output logic [RD_W-1:0] rdW
);

  // E-stage registers
  logic            r_validE;
  logic            r_regWriteE;
  logic [1:0]      r_resultSrcE;
  logic            r_memWriteE;
  logic [1:0]      r_jumpE;
  logic [2:0]      r_branchE;
  logic [2:0]      r_ALUControlE;
  logic            r_ALUSrcE;
  logic [RD_W-1:0] r_rdE;

  // M-stage registers
  logic            r_validM;
  logic            r_regWriteM;
  logic            r_memWriteM;
  logic [1:0]      r_resultSrcM;
  logic [RD_W-1:0] r_rdM;

  // W-stage registers
  logic            r_regWriteW;
  logic [1:0]      r_resultSrcW;
  logic [RD_W-1:0] r_rdW;

  // Combinational E-stage decisions
  logic            w_takeD;
  logic            w_brTaken;
  logic [1:0]      w_pcSrcE;

  // A real instruction enters E only when the slot is valid and not flushed;
  // flush always wins over validD.
  assign w_takeD = validD & ~flushE;

  // E register: capture the D bundle or insert an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validE      <= 1'b0;
      r_regWriteE   <= 1'b0;
      r_resultSrcE  <= 2'b00;
      r_memWriteE   <= 1'b0;
      r_jumpE       <= 2'b00;
      r_branchE     <= 3'b000;
      r_ALUControlE <= 3'b000;
      r_ALUSrcE     <= 1'b0;
      r_rdE         <= {RD_W{1'b0}};
    end else if (w_takeD) begin
      r_validE      <= 1'b1;
      r_regWriteE   <= regWriteD & validD;
      r_resultSrcE  <= resultSrcD;
      r_memWriteE   <= memWriteD & validD;
      r_jumpE       <= jumpD;
      r_branchE     <= branchD;
      r_ALUControlE <= ALUControlD;
      r_ALUSrcE     <= ALUSrcD;
      r_rdE         <= rdD;
    end else begin
      r_validE      <= 1'b0;
      r_regWriteE   <= 1'b0;
      r_resultSrcE  <= 2'b00;
      r_memWriteE   <= 1'b0;
      r_jumpE       <= 2'b00;
      r_branchE     <= 3'b000;
      r_ALUControlE <= 3'b000;
      r_ALUSrcE     <= 1'b0;
      r_rdE         <= {RD_W{1'b0}};
    end
  end

  // M register: advances from E every clock, write enables gated by validE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validM     <= 1'b0;
      r_regWriteM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_resultSrcM <= 2'b00;
      r_rdM        <= {RD_W{1'b0}};
    end else begin
      r_validM     <= r_validE;
      r_regWriteM  <= r_regWriteE & r_validE;
      r_memWriteM  <= r_memWriteE & r_validE;
      r_resultSrcM <= r_resultSrcE;
      r_rdM        <= r_rdE;
    end
  end

  // W register: advances from M every clock, write enable gated by validM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regWriteW  <= 1'b0;
      r_resultSrcW <= 2'b00;
      r_rdW        <= {RD_W{1'b0}};
    end else begin
      r_regWriteW  <= r_regWriteM & r_validM;
      r_resultSrcW <= r_resultSrcM;
      r_rdW        <= r_rdM;
    end
  end

  // Branch condition evaluation from the E-stage ALU flags
  always_comb begin
    w_brTaken = 1'b0;
    case (r_branchE)
      3'b001:  w_brTaken = zeroE;
      3'b010:  w_brTaken = ~zeroE;
      3'b011:  w_brTaken = ltE;
      3'b100:  w_brTaken = ~ltE;
      3'b101:  w_brTaken = ltuE;
      3'b110:  w_brTaken = ~ltuE;
      default: w_brTaken = 1'b0;
    endcase
  end

  // Next-PC select: jumps override branches; reserved encodings fall back to PC+4
  always_comb begin
    w_pcSrcE = 2'b00;
    if (!r_validE) begin
      w_pcSrcE = 2'b00;
    end else if (r_jumpE == 2'b01) begin
      w_pcSrcE = 2'b01;
    end else if (r_jumpE == 2'b10) begin
      w_pcSrcE = 2'b10;
    end else if (r_jumpE == 2'b11) begin
      w_pcSrcE = 2'b00;
    end else if (w_brTaken) begin
      w_pcSrcE = 2'b01;
    end else begin
      w_pcSrcE = 2'b00;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  logic             r_validW;
  logic [CNT_W-1:0] r_retiredCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             w_flushHit;

  // A flush is counted only when it actually discards work: a valid D slot or
  // a redirect coming out of E.
  assign w_flushHit = flushE & (validD | (w_pcSrcE != 2'b00));

  // W valid tracking for retirement counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validW <= 1'b0;
    end else begin
      r_validW <= r_validM;
    end
  end

  // Performance counters, wrap naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retiredCnt <= {CNT_W{1'b0}};
      r_flushCnt   <= {CNT_W{1'b0}};
    end else begin
      r_retiredCnt <= r_retiredCnt + {{(CNT_W-1){1'b0}}, r_validW};
      r_flushCnt   <= r_flushCnt + {{(CNT_W-1){1'b0}}, w_flushHit};
    end
  end

  assign retiredCnt = r_retiredCnt;
  assign flushCnt   = r_flushCnt;
`endif

  assign ALUControlE = r_ALUControlE;
  assign ALUSrcE     = r_ALUSrcE;
  assign pcSrcE      = w_pcSrcE;
  assign loadE       = r_validE & (r_resultSrcE == 2'b01);
  assign rdE         = r_rdE;
  assign regWriteM   = r_regWriteM;
  assign memWriteM   = r_memWriteM;
  assign resultSrcM  = r_resultSrcM;
  assign rdM         = r_rdM;
  assign regWriteW   = r_regWriteW;
  assign resultSrcW  = r_resultSrcW;
  assign rdW         = r_rdW;

endmodule
